// File: rtl/shift32_seq.sv
// shift32_seq: sequential 32-bit shifter/rotator built from 8-bit funnel stages.
// Right shifts read bits [31:0] of {fill, din} >> n. Left shifts are done as a
// right shift of {din, G} by 32 - n.
// The default build has one funnel stage and writes one output byte per RUN cycle.
// Define SHIFT32_SEQ_FAST_EN to use four parallel funnel stages, so RUN takes one cycle.

// One funnel lane: take the low byte of {hi, lo} >> sh.
module shift32_seq_funnel (
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  input  logic [2:0] sh,
  output logic [7:0] y
);
  // Combinational funnel; the upper byte of the shifted pair is not needed.
  always_comb y = 8'({hi, lo} >> sh);
endmodule

module shift32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] din,
  input  logic [4:0]  n,
  input  logic        lr,
  input  logic        ar,
  input  logic        rot,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [31:0]            c_din;
  logic [4:0]             c_n;
  logic                   c_lr, c_ar, c_rot;
  logic [NUM_LANES-1:0][7:0] dout_r;

  // Build the 64-bit source and the right-shift amount.
  // A left shift by n equals a right shift of {din, G} by 32 - n.
  // When n = 0, the right-shift source is used so that din passes through in every mode.
  logic             left_eff;
  logic [4:0]       amt;
  logic [1:0]       q;
  logic [2:0]       r;
  logic [31:0]      fill;
  logic [7:0][7:0]  src;

  assign left_eff = c_lr && (c_n != 5'd0);
  assign amt      = left_eff ? (~c_n + 5'd1) : c_n;
  assign q        = amt[4:3];
  assign r        = amt[2:0];
  assign fill     = c_rot ? c_din : (c_ar ? {32{c_din[31]}} : 32'h0);
  assign src      = left_eff ? {c_din, (c_rot ? c_din : 32'h0)} : {fill, c_din};
  assign dout     = dout_r;

`ifdef SHIFT32_SEQ_FAST_EN
  // Four lanes: lane k reads source bytes k+q and k+q+1 (the highest index is 7).
  logic [NUM_LANES-1:0][7:0] lane_y;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [2:0] idx;
    assign idx = 3'(k) + {1'b0, q};
    shift32_seq_funnel u_funnel (
      .hi (src[idx + 3'd1]),
      .lo (src[idx]),
      .sh (r),
      .y  (lane_y[k])
    );
  end
`else
  // A single lane whose byte index follows the RUN counter.
  logic [1:0] cnt;
  logic [2:0] idx;
  logic [7:0] lane_y;
  assign idx = {1'b0, cnt} + {1'b0, q};
  shift32_seq_funnel u_funnel (
    .hi (src[idx + 3'd1]),
    .lo (src[idx]),
    .sh (r),
    .y  (lane_y)
  );
`endif

  // Control FSM: capture on accept, write result bytes during RUN, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      c_din  <= '0;
      c_n    <= '0;
      c_lr   <= 1'b0;
      c_ar   <= 1'b0;
      c_rot  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout_r <= '0;
`ifndef SHIFT32_SEQ_FAST_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            c_din <= din;
            c_n   <= n;
            c_lr  <= lr;
            c_ar  <= ar;
            c_rot <= rot;
            busy  <= 1'b1;
            state <= RUN;
`ifndef SHIFT32_SEQ_FAST_EN
            cnt   <= '0;
`endif
          end
        end
        RUN: begin
`ifdef SHIFT32_SEQ_FAST_EN
          dout_r <= lane_y;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
`else
          dout_r[cnt] <= lane_y;
          cnt         <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
